// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the fully-connected layer datapath and the
// downstream argmax comparator.
//   - default widths (DEF_DATA_W, DEF_FRAC_W, DEF_N_OUT)
//   - acc_w():  accumulator width that cannot overflow over n_in products
//   - addr_w(): address width for an n-entry port (never zero)
//   - fc_state_e: engine FSM state encoding
//   - SAT_MAX / SAT_MIN: score saturation limits at the default width
package fc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 11;
  localparam int DEF_N_OUT  = 10;

  localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = 16'sh8000;

  // Full product is 2*data_w bits; clog2(n_in) growth for the sum, plus one
  // spare bit so the signed extremes never wrap.
  function automatic int acc_w(input int n_in, input int data_w);
    return 2 * data_w + $clog2(n_in) + 1;
  endfunction

  // A one-entry memory still needs a 1-bit address port.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fc_layer_engine_if.sv
// fc_layer_engine_if: control, memory read ports and score bus of the
// fully-connected layer engine.
//   master : host/memory side (drives enable and read data)
//   slave  : engine side (drives addresses, busy, done, out_vec)
// Read data is expected one cycle after the matching address.
interface fc_layer_engine_if
  import fc_pkg::*;
#(
  parameter int N_IN   = 84,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int DATA_W = DEF_DATA_W
) ();

  localparam int FAW = addr_w(N_IN);
  localparam int WAW = addr_w(N_IN * N_OUT);
  localparam int BAW = addr_w(N_OUT);

  logic                      enable;
  logic                      busy;
  logic                      done;
  logic [N_OUT*DATA_W-1:0]   out_vec;
  logic [FAW-1:0]            feat_addr;
  logic [DATA_W-1:0]         feat_data;
  logic [WAW-1:0]            w_addr;
  logic [DATA_W-1:0]         w_data;
  logic [BAW-1:0]            b_addr;
  logic [DATA_W-1:0]         b_data;

  modport master (
    output enable, feat_data, w_data, b_data,
    input  busy, done, out_vec, feat_addr, w_addr, b_addr
  );

  modport slave (
    input  enable, feat_data, w_data, b_data,
    output busy, done, out_vec, feat_addr, w_addr, b_addr
  );

endinterface

// File: rtl/fc_requant.sv
// fc_requant: converts a wide MAC accumulator into a DATA_W score.
//   i_acc   : signed accumulator, FRAC_W*2 fractional bits
//   i_bias  : signed bias, FRAC_W fractional bits
//   o_score : floor((acc + bias<<FRAC_W) / 2^FRAC_W), saturated to DATA_W
// Purely combinational; shared with the earlier FC layers.
module fc_requant
  import fc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = acc_w(84, DEF_DATA_W)
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [DATA_W-1:0] i_bias,
  output logic signed [DATA_W-1:0] o_score
);

  // One extra bit so adding the aligned bias cannot wrap.
  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [SW-1:0] w_acc_ext;
  logic signed [SW-1:0] w_bias_ext;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_shr;

  assign w_acc_ext  = {i_acc[ACC_W-1], i_acc};
  assign w_bias_ext = {{(SW-DATA_W){i_bias[DATA_W-1]}}, i_bias} <<< FRAC_W;
  assign w_sum      = w_acc_ext + w_bias_ext;
  // Arithmetic shift floors toward -inf; no rounding is intended.
  assign w_shr      = w_sum >>> FRAC_W;

  always_comb begin
    o_score = w_shr[DATA_W-1:0];
    if (w_shr > MAXV)      o_score = MAXV[DATA_W-1:0];
    else if (w_shr < MINV) o_score = MINV[DATA_W-1:0];
  end

endmodule

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: final fully-connected layer, one time-multiplexed MAC.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus.enable : start request, only looked at in IDLE
//   bus.*_addr / bus.*_data : feature, weight (j*N_IN+i) and bias (j) reads,
//                data one cycle after address
//   bus.out_vec: out[j] at [j*DATA_W +: DATA_W], held until overwritten
//   bus.busy   : high while neurons are being computed
//   bus.done   : one-cycle pulse once every score is written
// Per neuron: N_IN+1 MAC cycles (address i on cycle i, product i folded in on
// cycle i+1) then one FINAL cycle that requantises into out[j].
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int N_IN   = 84,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic               clk,
  input  logic               reset,
  fc_layer_engine_if.slave   bus
);

  localparam int ACC_W = acc_w(N_IN, DATA_W);
  localparam int FAW   = addr_w(N_IN);
  localparam int WAW   = addr_w(N_IN * N_OUT);
  localparam int BAW   = addr_w(N_OUT);
  localparam int CW    = $clog2(N_IN + 1);

  localparam logic [CW-1:0]  C_LAST      = CW'(N_IN);
  localparam logic [CW-1:0]  C_ADDR_LAST = CW'(N_IN - 1);
  localparam logic [BAW-1:0] J_LAST      = BAW'(N_OUT - 1);

  fc_state_e r_state, w_state_nxt;

  logic [CW-1:0]                   r_cyc;       // MAC cycle within neuron
  logic signed [ACC_W-1:0]         r_acc;
  logic [FAW-1:0]                  r_feat_addr;
  logic [WAW-1:0]                  r_w_addr;
  logic [BAW-1:0]                  r_b_addr;    // doubles as neuron index j
  logic [N_OUT-1:0][DATA_W-1:0]    r_out;

  logic signed [2*DATA_W-1:0]      w_prod;
  logic signed [ACC_W-1:0]         w_prod_ext;
  logic signed [DATA_W-1:0]        w_score;

  assign w_prod     = $signed(bus.feat_data) * $signed(bus.w_data);
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  fc_requant #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_requant (
    .i_acc   (r_acc),
    .i_bias  ($signed(bus.b_data)),
    .o_score (w_score)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.enable) w_state_nxt = ST_MAC;
      ST_MAC:   if (r_cyc == C_LAST) w_state_nxt = ST_FINAL;
      ST_FINAL: w_state_nxt = (r_b_addr == J_LAST) ? ST_DONE : ST_MAC;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy = (r_state == ST_MAC) || (r_state == ST_FINAL);
    bus.done = (r_state == ST_DONE);
  end

  // Datapath. Addresses are registered one cycle ahead of use, so the values
  // for cycle 0 of a neuron are loaded on the edge that enters MAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc       <= '0;
      r_acc       <= '0;
      r_feat_addr <= '0;
      r_w_addr    <= '0;
      r_b_addr    <= '0;
      r_out       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.enable) begin
            r_cyc       <= '0;
            r_acc       <= '0;
            r_feat_addr <= '0;
            r_w_addr    <= '0;
            r_b_addr    <= '0;
          end
        end
        ST_MAC: begin
          r_cyc <= r_cyc + 1'b1;
          // Cycle 0 has no data yet; cycles 1..N_IN carry products 0..N_IN-1.
          if (r_cyc != '0) r_acc <= r_acc + w_prod_ext;
          if (r_cyc < C_ADDR_LAST) begin
            r_feat_addr <= FAW'(r_cyc + 1'b1);
            r_w_addr    <= r_w_addr + 1'b1;
          end
        end
        ST_FINAL: begin
          r_out[r_b_addr] <= w_score;
          if (r_b_addr != J_LAST) begin
            r_cyc       <= '0;
            r_acc       <= '0;
            r_feat_addr <= '0;
            r_w_addr    <= r_w_addr + 1'b1;  // rolls onto (j+1)*N_IN
            r_b_addr    <= r_b_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.feat_addr = r_feat_addr;
  assign bus.w_addr    = r_w_addr;
  assign bus.b_addr    = r_b_addr;
  assign bus.out_vec   = r_out;

endmodule
